// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel/Scharr edge engine.
package sobel_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_COEF_EDGE = 3;
    localparam int DEF_COEF_MID  = 10;

    // Signed width that holds the largest possible kernel sum without overflow
    function automatic int inter_width(input int word_size, input int coef_edge, input int coef_mid);
        return word_size + $clog2(2 * coef_edge + coef_mid) + 1;
    endfunction

    function automatic logic [63:0] saturate(input logic [63:0] val, input int word_size);
        logic [63:0] max_v;
        max_v = (64'd1 << word_size) - 64'd1;
        if (val > max_v) begin
            return max_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: asynchronous read and synchronous write at the same
// address, so a same-cycle read returns the previous row's pixel.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int DEPTH     = 640,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem_r [DEPTH];

    assign rdata = mem_r[addr];

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 edge-magnitude engine: line buffers, window, raster counters
// and a two-stage pipeline. Optional macro SOBEL_THRESH_EN binarises q.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COEF_EDGE  = DEF_COEF_EDGE,
    parameter int COEF_MID   = DEF_COEF_MID
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [WORD_SIZE-1:0] in_pixel,
    input  logic [WORD_SIZE-1:0] threshold,
    output logic                 out_valid,
    output logic                 out_eof,
    output logic [WORD_SIZE-1:0] q
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int IW = inter_width(WORD_SIZE, COEF_EDGE, COEF_MID);
    localparam int MW = IW + 1;

    localparam logic signed [IW-1:0] CE = IW'(COEF_EDGE);
    localparam logic signed [IW-1:0] CM = IW'(COEF_MID);

    typedef logic signed [IW-1:0] inter_t;

    logic [XW-1:0]        x_r, cur_x_s, nxt_x_s;
    logic [YW-1:0]        y_r, cur_y_s, nxt_y_s;
    logic                 trig_s, trig_eof_s;
    logic [WORD_SIZE-1:0] lb0_rd_s, lb1_rd_s;
    logic [WORD_SIZE-1:0] win_r [9];
    logic                 win_vld_r, win_eof_r;
    inter_t               p_s [9];
    inter_t               dx_s, dy_s, dx_r, dy_r;
    logic                 s1_vld_r, s1_eof_r;
    logic signed [MW-1:0] dxe_s, dye_s;
    logic [MW-1:0]        abs_x_s, abs_y_s, mag_s;
    logic [WORD_SIZE-1:0] sat_s, res_s;

    // Effective raster position of the incoming pixel and its successor
    always_comb begin
        cur_x_s    = x_r;
        cur_y_s    = y_r;
        nxt_x_s    = x_r;
        nxt_y_s    = y_r;
        trig_s     = 1'b0;
        trig_eof_s = 1'b0;
        if (in_sof) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
        if (cur_x_s == XW'(IMG_WIDTH - 1)) begin
            nxt_x_s = '0;
            if (cur_y_s == YW'(IMG_HEIGHT - 1)) begin
                nxt_y_s = '0;
            end else begin
                nxt_y_s = cur_y_s + YW'(1);
            end
        end else begin
            nxt_x_s = cur_x_s + XW'(1);
            nxt_y_s = cur_y_s;
        end
        trig_s     = (cur_x_s >= XW'(2)) && (cur_y_s >= YW'(2));
        trig_eof_s = trig_s && (cur_x_s == XW'(IMG_WIDTH - 1)) && (cur_y_s == YW'(IMG_HEIGHT - 1));
    end

    // lb0 holds row y-1; lb1 receives what lb0 held, i.e. row y-2
    sobel_line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_x_s),
        .wdata (in_pixel),
        .rdata (lb0_rd_s)
    );

    sobel_line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_x_s),
        .wdata (lb0_rd_s),
        .rdata (lb1_rd_s)
    );

    // Stage 1 arithmetic: window index 0..8 is p1..p9, top-left first
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            p_s[i] = $signed({{(IW - WORD_SIZE){1'b0}}, win_r[i]});
        end
        dx_s = (CE * p_s[0] + CM * p_s[3] + CE * p_s[6]) - (CE * p_s[2] + CM * p_s[5] + CE * p_s[8]);
        dy_s = (CE * p_s[0] + CM * p_s[1] + CE * p_s[2]) - (CE * p_s[6] + CM * p_s[7] + CE * p_s[8]);
    end

    // Stage 2 arithmetic: |dx| + |dy| one bit wider, then saturate
    always_comb begin
        dxe_s   = MW'(dx_r);
        dye_s   = MW'(dy_r);
        abs_x_s = '0;
        abs_y_s = '0;
        if (dxe_s[MW-1]) begin
            abs_x_s = MW'(-dxe_s);
        end else begin
            abs_x_s = MW'(dxe_s);
        end
        if (dye_s[MW-1]) begin
            abs_y_s = MW'(-dye_s);
        end else begin
            abs_y_s = MW'(dye_s);
        end
        mag_s = abs_x_s + abs_y_s;
        sat_s = WORD_SIZE'(saturate(64'(mag_s), WORD_SIZE));
`ifdef SOBEL_THRESH_EN
        if (sat_s > threshold) begin
            res_s = '1;
        end else begin
            res_s = '0;
        end
`else
        res_s = sat_s;
`endif
    end

`ifndef SOBEL_THRESH_EN
    logic unused_thresh_s;
    assign unused_thresh_s = ^threshold;
`endif

    // Counters, window and pipeline advance only on accepted pixels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r       <= '0;
            y_r       <= '0;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= '0;
            end
            win_vld_r <= 1'b0;
            win_eof_r <= 1'b0;
            dx_r      <= '0;
            dy_r      <= '0;
            s1_vld_r  <= 1'b0;
            s1_eof_r  <= 1'b0;
        end else if (in_valid) begin
            x_r       <= nxt_x_s;
            y_r       <= nxt_y_s;
            win_r[0]  <= win_r[1];
            win_r[1]  <= win_r[2];
            win_r[2]  <= lb1_rd_s;
            win_r[3]  <= win_r[4];
            win_r[4]  <= win_r[5];
            win_r[5]  <= lb0_rd_s;
            win_r[6]  <= win_r[7];
            win_r[7]  <= win_r[8];
            win_r[8]  <= in_pixel;
            win_vld_r <= trig_s;
            win_eof_r <= trig_eof_s;
            dx_r      <= dx_s;
            dy_r      <= dy_s;
            s1_vld_r  <= win_vld_r;
            s1_eof_r  <= win_eof_r;
        end
    end

    // Output register: valid is a one-cycle pulse per accepted input, q holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            q         <= '0;
        end else begin
            out_valid <= in_valid & s1_vld_r;
            out_eof   <= in_valid & s1_vld_r & s1_eof_r;
            if (in_valid && s1_vld_r) begin
                q <= res_s;
            end
        end
    end

endmodule
